// File: rtl/dmem_write_buffer_if.sv
// Datapath/memory-side bus of the posted-store buffer.
// The slave modport is the buffer. The master modport is the datapath and memory side.
interface dmem_write_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              cpu_we;
  logic              cpu_re;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wd;
  logic [DATA_W-1:0] cpu_rd;
  logic              cpu_stall;
  logic              flush;
  logic              buf_empty;
  logic [CW-1:0]     buf_count;
  logic              mem_WE;
  logic [ADDR_W-1:0] mem_Address;
  logic [DATA_W-1:0] mem_WD;
  logic [DATA_W-1:0] mem_RD;

  modport slave (
    input  cpu_we, cpu_re, cpu_addr, cpu_wd, flush, mem_RD,
    output cpu_rd, cpu_stall, buf_empty, buf_count, mem_WE, mem_Address, mem_WD
  );

  modport master (
    output cpu_we, cpu_re, cpu_addr, cpu_wd, flush, mem_RD,
    input  cpu_rd, cpu_stall, buf_empty, buf_count, mem_WE, mem_Address, mem_WD
  );
endinterface

// File: rtl/dmem_write_buffer.sv
// Posted-store FIFO between the datapath and a single-port data memory.
// Loads own the memory port and are forwarded from the youngest buffered store. Stores drain on idle cycles.
module dmem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_write_buffer_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              w_load, w_full, w_drain, w_accept, w_hit;
  logic [DATA_W-1:0] w_fwd;
  logic [PW-1:0]     w_idx;

  // A simultaneous store and load is a store.
  // flush lets buffered stores take the port away from loads.
  assign w_load   = bus.cpu_re & ~bus.cpu_we;
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_drain  = (r_count != '0) & (~w_load | bus.flush);
  assign w_accept = bus.cpu_we & ~w_full;

  assign bus.cpu_stall   = bus.cpu_we & w_full;
  assign bus.buf_empty   = (r_count == '0);
  assign bus.buf_count   = r_count;
  assign bus.mem_WE      = w_drain;
  assign bus.mem_Address = w_drain ? r_addr[r_rd_ptr] : bus.cpu_addr;
  assign bus.mem_WD      = w_drain ? r_data[r_rd_ptr] : '0;
  assign bus.cpu_rd      = w_hit ? w_fwd : bus.mem_RD;

  // The walk goes from oldest to youngest, so the last match is the youngest store.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    w_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PW'(i);
      if ((CW'(i) < r_count) && (r_addr[w_idx] == bus.cpu_addr)) begin
        w_hit = 1'b1;
        w_fwd = r_data[w_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr[r_wr_ptr] <= bus.cpu_addr;
      r_data[r_wr_ptr] <= bus.cpu_wd;
    end
  end

  // The power-of-2 depth lets the pointers wrap on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_drain)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_accept) - CW'(w_drain);
    end
  end
endmodule
